// File: rtl/multi_pulse_generator.sv
// rtl/multi_pulse_generator.sv - Multi-channel delay/width/repetition pulse generator
//
// Optional feature macro: PULSE_GEN_SYNC_START_EN
//   defined   -> start and stop each pass through a two-flop synchronizer
//                before edge detection and use, adding 2 cycles of latency.
//   undefined -> start and stop are used directly.
//
// Ports:
//   clk                 rising-edge clock
//   reset_n             synchronous active-low reset
//   start[NUM_CH]       per-channel start request, rising edge triggers a run
//   stop[NUM_CH]        per-channel level abort, wins over a start edge
//   delay_cycles        per-channel low time before each pulse, CNT_W bits per channel
//   pulse_width_cycles  per-channel high time, CNT_W bits per channel
//   repetition          per-channel period count, REP_W bits per channel, 0 = infinite
//   pulse_out[NUM_CH]   registered pulse output
//   busy[NUM_CH]        registered, channel not idle
//   done[NUM_CH]        one-cycle strobe on normal completion
//   pulse_led           OR of all pulse_out
//   delay_led           OR of channels currently in their delay phase

module multi_pulse_generator #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int REP_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH*CNT_W-1:0] delay_cycles,
    input  logic [NUM_CH*CNT_W-1:0] pulse_width_cycles,
    input  logic [NUM_CH*REP_W-1:0] repetition,
    output logic [NUM_CH-1:0]       pulse_out,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic                    pulse_led,
    output logic                    delay_led
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    logic [NUM_CH-1:0] start_eff;
    logic [NUM_CH-1:0] stop_eff;
    logic [NUM_CH-1:0] start_prev;
    logic [NUM_CH-1:0] start_edge;
    logic [NUM_CH-1:0] in_delay;

`ifdef PULSE_GEN_SYNC_START_EN
    logic [NUM_CH-1:0] start_s1, start_s2;
    logic [NUM_CH-1:0] stop_s1, stop_s2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_s1 <= '0;
            start_s2 <= '0;
            stop_s1  <= '0;
            stop_s2  <= '0;
        end else begin
            start_s1 <= start;
            start_s2 <= start_s1;
            stop_s1  <= stop;
            stop_s2  <= stop_s1;
        end
    end

    assign start_eff = start_s2;
    assign stop_eff  = stop_s2;
`else
    assign start_eff = start;
    assign stop_eff  = stop;
`endif

    // Previous sample resets to 0 so a start already high at reset release
    // counts as an edge and launches exactly one run.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_prev <= '0;
        end else begin
            start_prev <= start_eff;
        end
    end

    assign start_edge = start_eff & ~start_prev;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] delay_s;
        logic [CNT_W-1:0] width_s;
        logic [REP_W-1:0] rep_s;
        logic [REP_W-1:0] rep_cnt;
        logic             pulse_r;
        logic             busy_r;
        logic             done_r;

        logic [CNT_W-1:0] delay_in;
        logic [CNT_W-1:0] width_in;
        logic [REP_W-1:0] rep_in;
        logic [REP_W-1:0] rep_next;

        assign delay_in = delay_cycles[i*CNT_W +: CNT_W];
        assign width_in = pulse_width_cycles[i*CNT_W +: CNT_W];
        assign rep_in   = repetition[i*REP_W +: REP_W];
        assign rep_next = rep_cnt + REP_ONE;

        // cnt holds cycles already spent in the current phase; the phase ends
        // when it reaches snapshot-1, so the full counter range is usable
        // without the counter itself ever wrapping.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                delay_s <= '0;
                width_s <= '0;
                rep_s   <= '0;
                rep_cnt <= '0;
                pulse_r <= 1'b0;
                busy_r  <= 1'b0;
                done_r  <= 1'b0;
            end else begin
                done_r <= 1'b0;
                if (stop_eff[i]) begin
                    state   <= ST_IDLE;
                    cnt     <= '0;
                    rep_cnt <= '0;
                    pulse_r <= 1'b0;
                    busy_r  <= 1'b0;
                end else if (start_edge[i]) begin
                    // A new edge always discards any run in progress.
                    delay_s <= delay_in;
                    width_s <= width_in;
                    rep_s   <= rep_in;
                    cnt     <= '0;
                    rep_cnt <= '0;
                    if (width_in == '0) begin
                        state   <= ST_IDLE;
                        pulse_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end else if (delay_in != '0) begin
                        state   <= ST_DELAY;
                        pulse_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        state   <= ST_PULSE;
                        pulse_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end else begin
                    case (state)
                        ST_DELAY: begin
                            if (cnt == delay_s - CNT_ONE) begin
                                state   <= ST_PULSE;
                                cnt     <= '0;
                                pulse_r <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                        ST_PULSE: begin
                            if (cnt == width_s - CNT_ONE) begin
                                cnt     <= '0;
                                rep_cnt <= rep_next;
                                if ((rep_s != '0) && (rep_next == rep_s)) begin
                                    state   <= ST_IDLE;
                                    pulse_r <= 1'b0;
                                    busy_r  <= 1'b0;
                                    done_r  <= 1'b1;
                                end else if (delay_s != '0) begin
                                    state   <= ST_DELAY;
                                    pulse_r <= 1'b0;
                                end
                                // With zero delay the pulse simply stays high
                                // into the next period.
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                        default: begin
                            state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end

        assign pulse_out[i] = pulse_r;
        assign busy[i]      = busy_r;
        assign done[i]      = done_r;
        assign in_delay[i]  = (state == ST_DELAY);
    end

    assign pulse_led = |pulse_out;
    assign delay_led = |in_delay;

endmodule

// File: tb/tb_multi_pulse_generator.sv
// tb/tb_multi_pulse_generator.sv - Self-checking bench for multi_pulse_generator

module tb_multi_pulse_generator;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int REP_W  = 16;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       stop;
    logic [NUM_CH*CNT_W-1:0] delay_cycles;
    logic [NUM_CH*CNT_W-1:0] pulse_width_cycles;
    logic [NUM_CH*REP_W-1:0] repetition;
    logic [NUM_CH-1:0]       pulse_out;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;
    logic                    pulse_led;
    logic                    delay_led;

    int total = 0;
    int bad   = 0;

    multi_pulse_generator #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .REP_W (REP_W)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .stop              (stop),
        .delay_cycles      (delay_cycles),
        .pulse_width_cycles(pulse_width_cycles),
        .repetition        (repetition),
        .pulse_out         (pulse_out),
        .busy              (busy),
        .done              (done),
        .pulse_led         (pulse_led),
        .delay_led         (delay_led)
    );

    always #5 clk = ~clk;

    // Reference model: each active channel is described only by how many
    // cycles have elapsed since its start edge (m_k) and its snapshot.
    bit     m_act  [NUM_CH];
    bit     m_prev [NUM_CH];
    longint m_k    [NUM_CH];
    longint m_d    [NUM_CH];
    longint m_w    [NUM_CH];
    longint m_r    [NUM_CH];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_cfg(input int ch, input int d, input int w, input int r);
        delay_cycles[ch*CNT_W +: CNT_W]       = CNT_W'(d);
        pulse_width_cycles[ch*CNT_W +: CNT_W] = CNT_W'(w);
        repetition[ch*REP_W +: REP_W]         = REP_W'(r);
    endtask

    // Advance the model across the coming rising edge using the current inputs.
    task automatic model_edge();
        bit edge_seen;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!reset_n) begin
                m_act[i]  = 0;
                m_prev[i] = 0;
                m_k[i]    = 0;
            end else begin
                edge_seen = start[i] && !m_prev[i];
                m_prev[i] = start[i];
                if (stop[i]) begin
                    m_act[i] = 0;
                end else if (edge_seen) begin
                    m_d[i] = longint'(delay_cycles[i*CNT_W +: CNT_W]);
                    m_w[i] = longint'(pulse_width_cycles[i*CNT_W +: CNT_W]);
                    m_r[i] = longint'(repetition[i*REP_W +: REP_W]);
                    m_k[i] = 0;
                    m_act[i] = (m_w[i] != 0);
                end else if (m_act[i]) begin
                    m_k[i]++;
                    if (m_r[i] != 0 && m_k[i] > m_r[i] * (m_d[i] + m_w[i]))
                        m_act[i] = 0;
                end
            end
        end
    endtask

    task automatic model_expect(output logic [NUM_CH-1:0] ep, output logic [NUM_CH-1:0] eb,
                                output logic [NUM_CH-1:0] ed, output logic [NUM_CH-1:0] edl);
        longint per;
        longint ph;
        ep = '0; eb = '0; ed = '0; edl = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_act[i]) begin
                per = m_d[i] + m_w[i];
                if (m_r[i] != 0 && m_k[i] == m_r[i] * per) begin
                    ed[i] = 1'b1;
                end else begin
                    eb[i] = 1'b1;
                    ph = m_k[i] % per;
                    if (ph < m_d[i]) edl[i] = 1'b1;
                    else             ep[i]  = 1'b1;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [NUM_CH-1:0] ep, eb, ed, edl;
        model_expect(ep, eb, ed, edl);
        chk("pulse_out", longint'(pulse_out), longint'(ep));
        chk("busy", longint'(busy), longint'(eb));
        chk("done", longint'(done), longint'(ed));
        chk("pulse_led", longint'(pulse_led), longint'(|ep));
        chk("delay_led", longint'(delay_led), longint'(|edl));
    endtask

    // Inputs are set at the falling edge; sample after the next rising edge,
    // at the following falling edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic              st;
        logic [NUM_CH-1:0] e_pulse;
        logic [NUM_CH-1:0] e_busy;
        logic [NUM_CH-1:0] e_done;
        logic              e_dled;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [9:0] seq;
        int         cnt_a;
        int         cnt_b;

        tbl[0] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[1] = '{1'b1, 4'b0000, 4'b0001, 4'b0000, 1'b1};
        tbl[2] = '{1'b1, 4'b0000, 4'b0001, 4'b0000, 1'b1};
        tbl[3] = '{1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b1};
        tbl[4] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0};
        tbl[5] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0};
        tbl[6] = '{1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        tbl[7] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[8] = '{1'b1, 4'b0000, 4'b0001, 4'b0000, 1'b1};

        reset_n = 1'b0;
        start = '0;
        stop = '0;
        delay_cycles = '0;
        pulse_width_cycles = '0;
        repetition = '0;
        @(negedge clk);
        tick();
        tick();
        chk("reset_outputs", longint'({pulse_out, busy, done, pulse_led, delay_led}), 0);
        reset_n = 1'b1;
        tick();

        // Channel 0: delay 3, width 2, one repetition.
        set_cfg(0, 3, 2, 1);
        for (int v = 0; v < 9; v++) begin
            start[0] = tbl[v].st;
            tick();
            chk($sformatf("tbl%0d_pulse", v), longint'(pulse_out), longint'(tbl[v].e_pulse));
            chk($sformatf("tbl%0d_busy", v), longint'(busy), longint'(tbl[v].e_busy));
            chk($sformatf("tbl%0d_done", v), longint'(done), longint'(tbl[v].e_done));
            chk($sformatf("tbl%0d_dled", v), longint'(delay_led), longint'(tbl[v].e_dled));
        end
        start[0] = 1'b0;
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
        tick();

        // Channel 1: delay 2, width 1, two repetitions.
        set_cfg(1, 2, 1, 2);
        start[1] = 1'b1;
        seq = '0;
        cnt_a = 0;
        for (int c = 0; c < 9; c++) begin
            tick();
            start[1] = 1'b0;
            if (c < 6) seq[5-c] = pulse_out[1];
            if (done[1]) cnt_a++;
        end
        chk("ch1_pattern", longint'(seq[5:0]), longint'(6'b001001));
        chk("ch1_done_count", cnt_a, 1);

        // Channel 2: zero width never starts, zero delay stays high until stop.
        set_cfg(2, 0, 0, 0);
        start[2] = 1'b1;
        cnt_a = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (busy[2] || pulse_out[2] || pulse_led || delay_led) cnt_a++;
        end
        chk("ch2_zero_width_idle", cnt_a, 0);
        start[2] = 1'b0;
        tick();
        set_cfg(2, 0, 10, 0);
        start[2] = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            start[2] = 1'b0;
            if (pulse_out[2]) cnt_a++;
            if (done[2]) cnt_b++;
        end
        chk("ch2_continuous_high", cnt_a, 30);
        stop[2] = 1'b1;
        tick();
        chk("ch2_stop_low", longint'(pulse_out[2]), 0);
        chk("ch2_no_done", longint'(cnt_b + int'(done[2])), 0);
        stop[2] = 1'b0;
        tick();

        // Channel 3: restart while busy discards the first run.
        set_cfg(3, 20, 15, 2);
        start[3] = 1'b1;
        tick();
        start[3] = 1'b0;
        for (int c = 1; c < 30; c++) tick();
        set_cfg(3, 5, 5, 1);
        start[3] = 1'b1;
        seq = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            start[3] = 1'b0;
            seq[9-c] = pulse_out[3];
        end
        chk("ch3_restart_pattern", longint'(seq), longint'(10'b0000011111));
        tick();
        chk("ch3_done", longint'(done[3]), 1);
        tick();

        // All channels at once, then reset in the middle of the runs.
        set_cfg(0, 1, 3, 2);
        set_cfg(1, 4, 2, 1);
        set_cfg(2, 0, 2, 3);
        set_cfg(3, 2, 2, 0);
        start = '1;
        tick();
        start = '0;
        for (int c = 0; c < 7; c++) tick();
        reset_n = 1'b0;
        tick();
        chk("midrun_reset_clear", longint'({pulse_out, busy, done, pulse_led, delay_led}), 0);
        // Start held high across reset release launches one run.
        start[0] = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        chk("reset_release_start", longint'(busy[0]), 1);
        for (int c = 0; c < 12; c++) tick();
        start = '0;
        stop = '1;
        tick();
        stop = '0;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 7) == 0) start[i] = ~start[i];
                stop[i] = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 5) == 0)
                    set_cfg(i, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                            int'($urandom_range(0, 3)));
            end
            reset_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_pulse_generator.md
MULTI_PULSE_GENERATOR -- requirements
Module: multi_pulse_generator

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent pulse channels (1..16).
REQ-002 Parameter CNT_W, default 32, width of delay and width counters.
REQ-003 Parameter REP_W, default 16, width of repetition count.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 start  input  NUM_CH  per-channel start request; rising edge triggers.
REQ-007 stop  input  NUM_CH  per-channel level abort.
REQ-008 delay_cycles  input  NUM_CH*CNT_W  per-channel delay; channel i at bits [i*CNT_W +: CNT_W].
REQ-009 pulse_width_cycles  input  NUM_CH*CNT_W  per-channel high time, same packing.
REQ-010 repetition  input  NUM_CH*REP_W  per-channel period count; 0 = infinite.
REQ-011 pulse_out  output  NUM_CH  per-channel pulse, registered.
REQ-012 busy  output  NUM_CH  channel not in IDLE, registered.
REQ-013 done  output  NUM_CH  one-cycle strobe on normal completion.
REQ-014 pulse_led  output  1  OR of all pulse_out.
REQ-015 delay_led  output  1  OR of channels in DELAY.

Function
REQ-016 Each channel SHALL run its own FSM with states IDLE, DELAY, PULSE; channels are fully independent.
REQ-017 Start edge SHALL be start[i]=1 with its previous registered sample 0; a level held high SHALL trigger once.
REQ-018 On a start edge the channel SHALL snapshot delay, width and repetition; later input changes SHALL NOT affect the run.
REQ-019 Start edge transitions: width=0 -> stay IDLE, no busy, no done; else delay>0 -> DELAY; else -> PULSE.
REQ-020 DELAY SHALL last exactly delay cycles (delay_led high), beginning the cycle after the start edge is sampled.
REQ-021 PULSE SHALL last exactly width cycles (pulse_out high), immediately following DELAY, with no gap.
REQ-022 At PULSE end, repetition counter SHALL increment; if repetition!=0 and count equals repetition -> IDLE with done=1 for exactly one cycle; else next period (DELAY, or PULSE if delay=0).
REQ-023 Period SHALL be delay+width cycles.
REQ-024 delay=0 with repetition!=1 SHALL keep pulse_out continuously high across periods.
REQ-025 repetition=0 with width>0 SHALL repeat indefinitely; done never asserted.
REQ-026 Start edge while busy SHALL discard the current run, resnapshot and restart per REQ-019 on the same edge; no done.
REQ-027 stop[i]=1 SHALL force IDLE on the next edge, clear pulse_out, and never assert done; stop SHALL take priority over a simultaneous start edge.
REQ-028 Counters SHALL compare against snapshot values without wrap; a count of 2^CNT_W-1 SHALL be honoured exactly.
REQ-029 Repetition counter SHALL be REP_W bits.

Reset
REQ-030 reset_n=0 at a clock edge SHALL put all channels in IDLE; pulse_out, busy, done, pulse_led, delay_led and counters SHALL be 0.
REQ-031 Reset mid-run SHALL abort without done.
REQ-032 Start edge-detect registers SHALL reset to 0, so a start high at reset release SHALL trigger one run.

Configuration
REQ-033 Macro PULSE_GEN_SYNC_START_EN defined: start and stop SHALL each pass through a two-flop synchronizer before edge detection/use, adding exactly 2 cycles latency to every REQ-020/REQ-027 timing.
REQ-034 Macro undefined: no synchronizer; start and stop SHALL be used directly with the timing stated above.

Verification
REQ-035 Ch0 delay=3, width=2, rep=1, start edge: delay_led 3 cycles, then pulse_out 2 cycles, done 1 cycle, then all outputs 0.
REQ-036 Ch1 delay=2, width=1, rep=2: pattern 0,0,1,0,0,1, then idle; done once; other channels stay 0.
REQ-037 Ch2 delay=0, width=0, rep=0: no busy, pulse or LED activity for 20 cycles; delay=0, width=10, rep=0: pulse_out high continuously until stop, then low the next cycle, no done.
REQ-038 Ch3 delay=20, width=15, rep=2; start edge re-issued at cycle 30 with delay=5, width=5, rep=1: first run aborts, new run gives 5 low, 5 high, done.
REQ-039 All channels started on the same cycle with different settings: each matches its own timing; pulse_led and delay_led equal the OR; reset asserted mid-run clears all outputs the next cycle.
